sevenseg_scan_mux: RTL and testbench

- Parametrised N-digit multiplexed seven-segment display driver; generalises the existing fixed two-digit An0/An1 + ca..cg driver.
- Scans one digit per refresh slot and decodes a 4-bit nibble per digit to hex glyphs 0-F.
- Adds per-digit decimal points, 16-level PWM brightness and tear-free double-buffered value updates.
- Sits between datapath blocks (counters, BCD converters) and the board anode/segment pins.

---
 rtl/sevenseg_pkg.sv | 27 ++
 rtl/sevenseg_scan_mux_if.sv | 24 ++
 rtl/sevenseg_glyph_dec.sv | 9 +
 rtl/sevenseg_scan_mux.sv | 169 ++++++++++++++++
 tb/tb_sevenseg_scan_mux.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan multiplexer: glyph table, segment
// bit positions and the digit-index width helper.
package sevenseg_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_MASK = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                        (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                        (1 << SEG_G));

   // Hex glyphs 0-F, active-high, segment a in bit 0.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sevenseg_scan_mux_if.sv
// Datapath-facing bus of the seven-segment scan multiplexer: value/dp/brightness
// inputs and the anode/segment pin outputs.
interface sevenseg_scan_mux_if #(
   parameter int N_DIGITS = 4
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   value_in;
   logic [N_DIGITS-1:0]     dp_in;
   logic [3:0]              bright;
   logic [N_DIGITS-1:0]     an;
   logic [6:0]              seg;
   logic                    dp;
   logic                    frame_tick;

   modport master (
      output load, value_in, dp_in, bright,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  load, value_in, dp_in, bright,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/sevenseg_glyph_dec.sv
// Combinational nibble to seven-segment glyph decoder (active-high, a = bit 0).
module sevenseg_glyph_dec
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);
   assign glyph = GLYPH_TABLE[nibble];
endmodule

// File: rtl/sevenseg_scan_mux.sv
// N-digit multiplexed seven-segment driver with PWM brightness and double-buffered
// updates. Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_mux
   import sevenseg_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int ACTIVE_LOW  = 1
)(
   input  logic             clk,
   input  logic             arst,
   sevenseg_scan_mux_if.slave bus
);
   localparam int IDX_W = idx_width(N_DIGITS);
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam logic POL = (ACTIVE_LOW != 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_OFF = POL ? SEG_MASK : 7'h00;

   logic [PRE_W-1:0]      prescaler;
   logic [IDX_W-1:0]      digit_idx;
   logic [3:0]            pwm_cnt;
   logic                  slot_end;
   logic                  frame_end;
   logic                  frame_tick_q;
   logic [4*N_DIGITS-1:0] shadow_val;
   logic [4*N_DIGITS-1:0] active_val;
   logic [4*N_DIGITS-1:0] next_val;
   logic [N_DIGITS-1:0]   shadow_dp;
   logic [N_DIGITS-1:0]   active_dp;
   logic [N_DIGITS-1:0]   next_dp;
   logic [N_DIGITS-1:0]   blank;
   logic                  pending;
   logic                  take_active;
   logic [3:0]            nibble;
   logic [6:0]            glyph;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [N_DIGITS-1:0]   digit_sel;
   logic                  pwm_on;
   logic [N_DIGITS-1:0]   an_raw;
   logic [N_DIGITS-1:0]   an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   assign slot_end  = (prescaler == LAST_PRE);
   assign frame_end = slot_end && (digit_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (arst) begin
         prescaler    <= '0;
         digit_idx    <= '0;
         pwm_cnt      <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         pwm_cnt      <= pwm_cnt + 4'd1;
         frame_tick_q <= frame_end;
         if (slot_end) begin
            prescaler <= '0;
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   // A load landing exactly on the frame boundary bypasses the shadow buffer.
   always_comb begin
      take_active = 1'b0;
      next_val    = shadow_val;
      next_dp     = shadow_dp;
      if (frame_end && bus.load) begin
         take_active = 1'b1;
         next_val    = bus.value_in;
         next_dp     = bus.dp_in;
      end else if (frame_end && pending) begin
         take_active = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
         pending    <= 1'b0;
      end else begin
         if (take_active) begin
            active_val <= next_val;
            active_dp  <= next_dp;
         end
         if (bus.load) begin
            shadow_val <= bus.value_in;
            shadow_dp  <= bus.dp_in;
         end
         if (frame_end)
            pending <= 1'b0;
         else if (bus.load)
            pending <= 1'b1;
      end
   end

`ifdef SEVENSEG_LZB_EN
   // A digit stays lit if it or any higher digit holds a nonzero nibble or a dp.
   function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [4*N_DIGITS-1:0] v,
                                                    input logic [N_DIGITS-1:0]   d);
      logic keep;
      keep     = 1'b0;
      lzb_mask = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         keep        = keep | (v[4*i +: 4] != 4'd0) | d[i];
         lzb_mask[i] = ~keep;
      end
   endfunction

   always_ff @(posedge clk) begin
      if (arst)
         blank <= {{(N_DIGITS-1){1'b1}}, 1'b0};
      else if (take_active)
         blank <= lzb_mask(next_val, next_dp);
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      nibble    = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      digit_sel = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            nibble       = active_val[4*i +: 4];
            cur_dp       = active_dp[i];
            cur_blank    = blank[i];
            digit_sel[i] = 1'b1;
         end
      end
   end

   assign pwm_on = (bus.bright == 4'hF) || (pwm_cnt < bus.bright);
   assign an_raw = (pwm_on && !cur_blank) ? digit_sel : '0;

   sevenseg_glyph_dec u_glyph_dec (
      .nibble (nibble),
      .glyph  (glyph)
   );

   // Polarity is folded in here so every pin leaves a flop with the same latency.
   always_ff @(posedge clk) begin
      if (arst) begin
         an_q  <= {N_DIGITS{POL}};
         seg_q <= SEG_OFF;
         dp_q  <= POL;
      end else begin
         an_q  <= an_raw ^ {N_DIGITS{POL}};
         seg_q <= glyph ^ SEG_OFF;
         dp_q  <= cur_dp ^ POL;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Self-checking bench for sevenseg_scan_mux (4 digits, 20-cycle slots, active-low)
// against a time-arithmetic reference model of the display.
`timescale 1ns/1ps
module tb_sevenseg_scan_mux;
   localparam int N     = 4;
   localparam int DIV   = 20;
   localparam int FRAME = N * DIV;

   localparam logic [6:0] REF_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic clk = 1'b0;
   logic arst;

   sevenseg_scan_mux_if #(.N_DIGITS(N)) bus ();

   sevenseg_scan_mux #(
      .N_DIGITS    (N),
      .REFRESH_DIV (DIV),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          cnt      = 0;
   logic [15:0] m_active = '0;
   logic [15:0] m_shadow = '0;
   logic [3:0]  m_dp     = '0;
   logic [3:0]  m_sdp    = '0;
   bit          m_pending = 1'b0;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic        exp_ft;

`ifdef SEVENSEG_LZB_EN
   function automatic bit digit_shown(input int s);
      if (s == 0) return 1'b1;
      for (int j = s; j < N; j++)
         if (4'(m_active >> (4*j)) != 4'd0 || m_dp[j]) return 1'b1;
      return 1'b0;
   endfunction
`endif

   // cnt is the number of clock edges since reset; the pins show the state at cnt-1.
   task automatic step();
      int         slot;
      logic [3:0] pwm;
      logic [3:0] nib;
      bit         vis;
      @(posedge clk);
      if (arst) begin
         cnt       = 0;
         m_active  = '0;
         m_shadow  = '0;
         m_dp      = '0;
         m_sdp     = '0;
         m_pending = 1'b0;
         exp_an    = 4'hF;
         exp_seg   = 7'h7F;
         exp_dp    = 1'b1;
         exp_ft    = 1'b0;
      end else begin
         slot = (cnt / DIV) % N;
         pwm  = 4'(cnt % 16);
         nib  = 4'(m_active >> (4*slot));
         vis  = 1'b1;
`ifdef SEVENSEG_LZB_EN
         vis  = digit_shown(slot);
`endif
         exp_an  = ((bus.bright == 4'hF || pwm < bus.bright) && vis) ? ~(4'b0001 << slot) : 4'hF;
         exp_seg = ~REF_GLYPH[nib];
         exp_dp  = ~m_dp[slot];
         exp_ft  = ((cnt % FRAME) == FRAME - 1);
         if ((cnt % FRAME) == FRAME - 1) begin
            if (bus.load) begin
               m_active  = bus.value_in;
               m_dp      = bus.dp_in;
               m_pending = 1'b0;
            end else if (m_pending) begin
               m_active  = m_shadow;
               m_dp      = m_sdp;
               m_pending = 1'b0;
            end
         end else if (bus.load) begin
            m_shadow  = bus.value_in;
            m_sdp     = bus.dp_in;
            m_pending = 1'b1;
         end
         cnt++;
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
      bus.load     = ld;
      bus.value_in = v;
      bus.dp_in    = d;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      bus.bright = 4'hF;
      step();
      step();
      checks++;
      if (bus.an !== 4'hF) begin failures++; $display("[TB] FAIL reset_an got=%b want=1111", bus.an); end
      checks++;
      if (bus.seg !== 7'h7F) begin failures++; $display("[TB] FAIL reset_seg got=%b want=1111111", bus.seg); end
      checks++;
      if (bus.dp !== 1'b1 || bus.frame_tick !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_dp_ft got dp=%b ft=%b want dp=1 ft=0", bus.dp, bus.frame_tick);
      end
      arst = 1'b0;
   endtask

   task automatic test_scan();
      bit seen;
      applyStimulus(1'b1, 16'h1234, 4'h0);
      bus.bright = 4'hF;
      step();
      bus.load = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2*FRAME && !seen; i++) begin
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp || bus.frame_tick !== exp_ft) begin
            failures++;
            $display("[TB] FAIL scan_wait t=%0d an=%b/%b seg=%b/%b dp=%b/%b ft=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp, bus.frame_tick, exp_ft);
         end
         seen = (bus.frame_tick === 1'b1);
      end
      checks++;
      if (!seen) begin failures++; $display("[TB] FAIL frame_tick_timeout got=none want=pulse"); end
      for (int k = 0; k < FRAME; k++) begin
         step();
         checks++;
         if (bus.an !== ~(4'b0001 << (k / DIV))) begin
            failures++; $display("[TB] FAIL scan_anode k=%0d got=%b want=%b", k, bus.an, ~(4'b0001 << (k / DIV)));
         end
         checks++;
         if (bus.seg !== exp_seg || bus.dp !== exp_dp || bus.frame_tick !== exp_ft) begin
            failures++; $display("[TB] FAIL scan_seg k=%0d seg=%b/%b dp=%b/%b", k, bus.seg, exp_seg, bus.dp, exp_dp);
         end
         if (bus.an === 4'b1110) begin
            checks++;
            if (bus.seg !== 7'b0011001) begin failures++; $display("[TB] FAIL digit0_glyph got=%b want=0011001", bus.seg); end
         end
      end
   endtask

   task automatic test_double_buffer();
      logic [15:0] v;
      while ((cnt % FRAME) != DIV) step();
      applyStimulus(1'b1, 16'hABCD, 4'h0);
      step();
      bus.load = 1'b0;
      while ((cnt % FRAME) != 0) begin
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
            failures++; $display("[TB] FAIL dbuf_old t=%0d an=%b/%b seg=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg);
         end
         if (bus.an === 4'b1011) begin
            checks++;
            if (bus.seg !== 7'b0100100) begin failures++; $display("[TB] FAIL dbuf_hold_2 got=%b want=0100100", bus.seg); end
         end
      end
      for (int k = 0; k < FRAME; k++) begin
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg || bus.frame_tick !== exp_ft) begin
            failures++; $display("[TB] FAIL dbuf_new t=%0d an=%b/%b seg=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg);
         end
         if (bus.an === 4'b1110) begin
            checks++;
            if (bus.seg !== 7'b0100001) begin failures++; $display("[TB] FAIL dbuf_show_D got=%b want=0100001", bus.seg); end
         end
      end
      v = 16'($urandom);
      while ((cnt % FRAME) != FRAME - 1) step();
      applyStimulus(1'b1, v, 4'h0);
      step();
      bus.load = 1'b0;
      step();
      checks++;
      if (bus.an !== 4'b1110 || bus.seg !== ~REF_GLYPH[v[3:0]]) begin
         failures++; $display("[TB] FAIL boundary_load an=%b seg=%b want an=1110 seg=%b", bus.an, bus.seg, ~REF_GLYPH[v[3:0]]);
      end
   endtask

   task automatic test_pwm();
      int on_cnt;
      bus.bright = 4'd4;
      while (((cnt - 1) % DIV) != DIV - 1) step();
      for (int s = 0; s < N; s++) begin
         on_cnt = 0;
         for (int k = 0; k < DIV; k++) begin
            step();
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg) begin
               failures++; $display("[TB] FAIL pwm t=%0d an=%b/%b seg=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg);
            end
            if (k < 16 && bus.an !== 4'hF) on_cnt++;
         end
         checks++;
         if (on_cnt != 4) begin failures++; $display("[TB] FAIL pwm_duty slot=%0d got=%0d want=4", s, on_cnt); end
      end
      bus.bright = 4'd0;
      for (int k = 0; k < 2*DIV; k++) begin
         step();
         checks++;
         if (bus.an !== 4'hF) begin failures++; $display("[TB] FAIL bright0 t=%0d got=%b want=1111", cnt, bus.an); end
      end
      bus.bright = 4'hF;
   endtask

   task automatic test_dp();
      applyStimulus(1'b1, 16'($urandom), 4'b0100);
      step();
      bus.load = 1'b0;
      for (int k = 0; k < 2*FRAME; k++) begin
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
            failures++; $display("[TB] FAIL dp_model t=%0d an=%b/%b dp=%b/%b", cnt, bus.an, exp_an, bus.dp, exp_dp);
         end
         if (k > FRAME) begin
            checks++;
            if ((bus.dp === 1'b0) != (bus.an === 4'b1011)) begin
               failures++; $display("[TB] FAIL dp_slot an=%b dp=%b want dp low only in slot 2", bus.an, bus.dp);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8*FRAME; k++) begin
         bus.load = ($urandom_range(0, 7) == 0);
         if (bus.load) begin
            bus.value_in = 16'($urandom);
            bus.dp_in    = 4'($urandom);
         end
         if ($urandom_range(0, 49) == 0) bus.bright = 4'($urandom);
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp || bus.frame_tick !== exp_ft) begin
            failures++;
            $display("[TB] FAIL random t=%0d an=%b/%b seg=%b/%b dp=%b/%b ft=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp, bus.frame_tick, exp_ft);
         end
      end
      bus.load   = 1'b0;
      bus.bright = 4'hF;
   endtask

   task automatic test_reset_midscan();
      bus.bright = 4'hF;
      while ((cnt % FRAME) != 2*DIV + 5) step();
      applyStimulus(1'b1, 16'h9876, 4'hF);
      step();
      bus.load = 1'b0;
      arst = 1'b1;
      step();
      arst = 1'b0;
      checks++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
         failures++; $display("[TB] FAIL midscan_reset an=%b seg=%b want an=1111 seg=1111111", bus.an, bus.seg);
      end
      step();
      checks++;
      if (bus.an !== 4'b1110) begin failures++; $display("[TB] FAIL restart_digit0 got=%b want=1110", bus.an); end
      for (int k = 0; k < 2*FRAME; k++) begin
         step();
         checks++;
         if (bus.seg !== 7'h40 || bus.dp !== 1'b1 || bus.an !== exp_an) begin
            failures++; $display("[TB] FAIL pending_lost t=%0d seg=%b dp=%b an=%b/%b want seg=1000000", cnt, bus.seg, bus.dp, bus.an, exp_an);
         end
      end
   endtask

`ifdef SEVENSEG_LZB_EN
   task automatic test_lzb();
      bit lit3;
      applyStimulus(1'b1, 16'h0042, 4'h0);
      step();
      bus.load = 1'b0;
      for (int k = 0; k < 2*FRAME; k++) begin
         step();
         checks++;
         if (bus.an !== exp_an || bus.seg !== exp_seg) begin
            failures++; $display("[TB] FAIL lzb t=%0d an=%b/%b seg=%b/%b", cnt, bus.an, exp_an, bus.seg, exp_seg);
         end
         if (k > FRAME) begin
            checks++;
            if (bus.an === 4'b0111 || bus.an === 4'b1011) begin failures++; $display("[TB] FAIL lzb_blank got an=%b", bus.an); end
         end
      end
      applyStimulus(1'b1, 16'h0042, 4'b1000);
      step();
      bus.load = 1'b0;
      lit3 = 1'b0;
      for (int k = 0; k < 2*FRAME; k++) begin
         step();
         if (bus.an === 4'b0111) lit3 = 1'b1;
      end
      checks++;
      if (!lit3) begin failures++; $display("[TB] FAIL lzb_dp_unblank got=dark want=digit3 lit"); end
   endtask
`endif

   initial begin
      arst = 1'b1;
      applyStimulus(1'b0, 16'h0000, 4'h0);
      bus.bright = 4'hF;
      test_reset();
      test_scan();
      test_double_buffer();
      test_pwm();
      test_dp();
      test_random();
      test_reset_midscan();
`ifdef SEVENSEG_LZB_EN
      test_lzb();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
